ras_ctrl: RTL and testbench

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/taiga_config.sv | 13 +
 rtl/taiga_types.sv | 27 ++
 rtl/ras_spec_log.sv | 75 +++++++
 rtl/ras_ctrl.sv | 143 ++++++++++++++
 tb/tb_ras_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/taiga_config.sv
// -----------------------------------------------------------------------------
// taiga_config
// Build-time configuration shared by the return-address-stack logic.
//   SPEC_LOG_DEPTH : number of uncommitted speculative RAS ops that can be
//                    tracked for rollback (power of two, >= 2)
//   RAS_DEPTH      : depth of the return address stack being controlled
// -----------------------------------------------------------------------------
package taiga_config;

   localparam int SPEC_LOG_DEPTH = 4;
   localparam int RAS_DEPTH      = 8;

endpackage

// File: rtl/taiga_types.sv
// -----------------------------------------------------------------------------
// taiga_types
// Types shared by the RAS controller and its speculation log.
//   ras_op_t         : kind of speculative RAS operation that was applied
//   ras_log_entry_t  : one undo record {op, saved top-of-stack, saved valid}
//   ras_ctrl_state_t : controller FSM state (also exported for debug)
// -----------------------------------------------------------------------------
package taiga_types;

   typedef enum logic [1:0] {
      PUSH = 2'd0,
      POP  = 2'd1,
      SWAP = 2'd2
   } ras_op_t;

   typedef struct packed {
      ras_op_t     op;
      logic [31:0] saved;
      logic        saved_v;
   } ras_log_entry_t;

   typedef enum logic {
      RC_IDLE    = 1'b0,
      RC_RECOVER = 1'b1
   } ras_ctrl_state_t;

endpackage

// File: rtl/ras_spec_log.sv
// -----------------------------------------------------------------------------
// ras_spec_log
// Circular buffer of speculative RAS undo records. New records enter at the
// tail; commits retire the oldest record at the head; rollback removes the
// newest record from the tail.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_tail_i     : append push_entry_i as the newest record
//   push_entry_i    : record to append
//   pop_head_i      : retire the oldest record (ignored by caller when empty)
//   pop_tail_i      : remove the newest record (rollback)
//   tail_entry_o    : newest record (valid when not empty)
//   full_o, empty_o : occupancy flags
//   last_o          : exactly one record held
// -----------------------------------------------------------------------------
module ras_spec_log
   import taiga_types::*;
#(
   parameter int DEPTH = taiga_config::SPEC_LOG_DEPTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push_tail_i,
   input  ras_log_entry_t push_entry_i,
   input  logic           pop_head_i,
   input  logic           pop_tail_i,
   output ras_log_entry_t tail_entry_o,
   output logic           full_o,
   output logic           empty_o,
   output logic           last_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ras_log_entry_t mem_q [DEPTH];
   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  newest_idx;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (pop_head_i) head_d = head_q + PW'(1);
      if (push_tail_i)     tail_d = tail_q + PW'(1);
      else if (pop_tail_i) tail_d = tail_q - PW'(1);
      count_d = count_q + CW'(push_tail_i) - CW'(pop_head_i) - CW'(pop_tail_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_tail_i) mem_q[tail_q] <= push_entry_i;
   end

   assign newest_idx   = tail_q - PW'(1);
   assign tail_entry_o = mem_q[newest_idx];
   assign full_o       = (count_q == CW'(DEPTH));
   assign empty_o      = (count_q == '0);
   assign last_o       = (count_q == CW'(1));

endmodule

// File: rtl/ras_ctrl.sv
// -----------------------------------------------------------------------------
// ras_ctrl
// Speculative return-address-stack controller. Fetch-time calls/returns are
// applied to the RAS immediately and logged; commits retire the oldest log
// record, a flush rolls the RAS back by undoing records newest-first, one per
// cycle, while busy is high.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   fetch_valid/_is_call/_is_ret     : predicted control transfer (both = swap)
//   fetch_ret_addr                   : link address to push
//   ctrl_ready                       : fetch op can be accepted this cycle
//   predict_addr, predict_valid      : predicted return target
//   commit                           : oldest speculative op resolved correct
//   flush                            : misprediction, undo uncommitted ops
//   ras_push, ras_pop, ras_new_addr  : RAS write controls
//   ras_addr, ras_valid              : RAS top-of-stack
//   busy                             : rollback in progress
//   dbg_state                        : FSM state
// Handshake: a fetch op is taken in any cycle where fetch_valid and ctrl_ready
// are both high and the op is a call and/or return; there is no holding, an
// op presented while ctrl_ready is low is simply not taken.
// -----------------------------------------------------------------------------
module ras_ctrl
   import taiga_types::*;
#(
   parameter int SPEC_LOG_DEPTH = taiga_config::SPEC_LOG_DEPTH,
   parameter int RAS_DEPTH      = taiga_config::RAS_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_valid,
   input  logic            fetch_is_call,
   input  logic            fetch_is_ret,
   input  logic [31:0]     fetch_ret_addr,
   output logic            ctrl_ready,
   output logic [31:0]     predict_addr,
   output logic            predict_valid,
   input  logic            commit,
   input  logic            flush,
   output logic            ras_push,
   output logic            ras_pop,
   output logic [31:0]     ras_new_addr,
   input  logic [31:0]     ras_addr,
   input  logic            ras_valid,
   output logic            busy,
   output ras_ctrl_state_t dbg_state
);

   if (SPEC_LOG_DEPTH < 2 || (SPEC_LOG_DEPTH & (SPEC_LOG_DEPTH - 1)) != 0) begin : g_bad_log_depth
      $error("ras_ctrl: SPEC_LOG_DEPTH must be a power of two >= 2");
   end
   if (RAS_DEPTH < 1) begin : g_bad_ras_depth
      $error("ras_ctrl: RAS_DEPTH must be >= 1");
   end

   ras_ctrl_state_t state_q, state_d;

   logic           log_push, log_pop_head, log_pop_tail;
   logic           log_full, log_empty, log_last;
   ras_log_entry_t log_new_entry, log_tail_entry;
   logic           idle, accept;

   assign idle = (state_q == RC_IDLE);

   // rst_n gates acceptance so no RAS write can escape while reset is held.
   assign ctrl_ready    = rst_n & idle & ~log_full & ~flush;
   assign accept        = fetch_valid & ctrl_ready & (fetch_is_call | fetch_is_ret);
   assign predict_addr  = ras_addr;
   assign predict_valid = ras_valid & idle;
   assign busy          = ~idle;
   assign dbg_state     = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RC_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      ras_push      = 1'b0;
      ras_pop       = 1'b0;
      ras_new_addr  = '0;
      log_push      = 1'b0;
      log_pop_head  = 1'b0;
      log_pop_tail  = 1'b0;
      log_new_entry = '0;
      case (state_q)
         RC_IDLE: begin
            log_pop_head = commit & ~log_empty;
            if (accept) begin
               log_push              = 1'b1;
               ras_push              = fetch_is_call;
               ras_pop               = fetch_is_ret;
               ras_new_addr          = fetch_is_call ? fetch_ret_addr : '0;
               log_new_entry.saved   = ras_addr;
               log_new_entry.saved_v = ras_valid;
               if (fetch_is_call && fetch_is_ret) log_new_entry.op = SWAP;
               else if (fetch_is_call)            log_new_entry.op = PUSH;
               else                               log_new_entry.op = POP;
            end
            // Rollback only if something survives the same-cycle commit.
            if (flush && !(log_empty || (log_last && log_pop_head)))
               state_d = RC_RECOVER;
         end
         RC_RECOVER: begin
            log_pop_tail = 1'b1;
            case (log_tail_entry.op)
               PUSH: ras_pop = 1'b1;
               POP: begin
                  if (log_tail_entry.saved_v) begin
                     ras_push     = 1'b1;
                     ras_new_addr = log_tail_entry.saved;
                  end
               end
               SWAP: begin
                  ras_push     = 1'b1;
                  ras_pop      = 1'b1;
                  ras_new_addr = log_tail_entry.saved;
               end
               default: ;
            endcase
            if (log_last) state_d = RC_IDLE;
         end
         default: state_d = RC_IDLE;
      endcase
   end

   ras_spec_log #(
      .DEPTH(SPEC_LOG_DEPTH)
   ) u_log (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_tail_i  (log_push),
      .push_entry_i (log_new_entry),
      .pop_head_i   (log_pop_head),
      .pop_tail_i   (log_pop_tail),
      .tail_entry_o (log_tail_entry),
      .full_o       (log_full),
      .empty_o      (log_empty),
      .last_o       (log_last)
   );

endmodule

// File: tb/tb_ras_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ras_ctrl
// Bench for ras_ctrl: a behavioural RAS (queue) answers the controller's
// push/pop, and a reference model holding the speculation log as a queue
// predicts every controller output each cycle.
// -----------------------------------------------------------------------------
module tb_ras_ctrl;

   localparam int DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        fetch_valid = 0, fetch_is_call = 0, fetch_is_ret = 0;
   logic [31:0] fetch_ret_addr = '0;
   logic        commit = 0, flush = 0;
   logic [31:0] ras_addr = '0;
   logic        ras_valid = 0;
   logic        ctrl_ready, predict_valid, ras_push, ras_pop, busy;
   logic [31:0] predict_addr, ras_new_addr;
   taiga_types::ras_ctrl_state_t dbg_state;

   ras_ctrl #(.SPEC_LOG_DEPTH(DEPTH), .RAS_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_is_call(fetch_is_call),
      .fetch_is_ret(fetch_is_ret), .fetch_ret_addr(fetch_ret_addr),
      .ctrl_ready(ctrl_ready), .predict_addr(predict_addr),
      .predict_valid(predict_valid), .commit(commit), .flush(flush),
      .ras_push(ras_push), .ras_pop(ras_pop), .ras_new_addr(ras_new_addr),
      .ras_addr(ras_addr), .ras_valid(ras_valid), .busy(busy),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard / environment state ----------------
   int total = 0;
   int bad   = 0;
   int busy_cnt = 0;
   int ras_ops  = 0;

   typedef struct {
      int          op;      // 0 call, 1 return, 2 swap
      logic [31:0] saved;
      logic        saved_v;
   } mentry_t;

   mentry_t     mlog[$];
   bit          m_rec = 0;
   logic [31:0] stk[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic refresh_ras();
      ras_valid = (stk.size() > 0);
      ras_addr  = (stk.size() > 0) ? stk[stk.size()-1] : 32'h0;
   endtask

   task automatic apply_ras(input bit p, input bit q, input logic [31:0] a);
      if (p && q) begin
         if (stk.size() > 0) void'(stk.pop_back());
         stk.push_back(a);
      end else if (p) begin
         stk.push_back(a);
      end else if (q) begin
         if (stk.size() > 0) void'(stk.pop_back());
      end
      refresh_ras();
   endtask

   // One clock cycle: drive, predict, compare, then let the RAS react.
   task automatic cycle(input bit v, input bit call, input bit ret,
                        input logic [31:0] a, input bit cm, input bit fl);
      bit          e_ready, e_push, e_pop, e_busy, e_pv, acc;
      logic [31:0] e_addr;
      mentry_t     ent;
      bit          s_push, s_pop;
      logic [31:0] s_addr;
      @(negedge clk);
      fetch_valid = v; fetch_is_call = call; fetch_is_ret = ret;
      fetch_ret_addr = a; commit = cm; flush = fl;
      #2;
      e_busy = m_rec;
      e_pv   = ras_valid && !m_rec;
      e_push = 0; e_pop = 0; e_addr = '0;
      if (!m_rec) begin
         e_ready = (mlog.size() < DEPTH) && !fl;
         acc = v && e_ready && (call || ret);
         e_push = acc && call;
         e_pop  = acc && ret;
         e_addr = (acc && call) ? a : 32'h0;
         if (cm && mlog.size() > 0) void'(mlog.pop_front());
         if (acc) begin
            ent.op = (call && ret) ? 2 : (call ? 0 : 1);
            ent.saved = ras_addr;
            ent.saved_v = ras_valid;
            mlog.push_back(ent);
         end
         if (fl && mlog.size() > 0) m_rec = 1;
      end else begin
         e_ready = 0;
         ent = mlog[mlog.size()-1];
         void'(mlog.pop_back());
         case (ent.op)
            0: e_pop = 1;
            1: if (ent.saved_v) begin e_push = 1; e_addr = ent.saved; end
            default: begin e_push = 1; e_pop = 1; e_addr = ent.saved; end
         endcase
         if (mlog.size() == 0) m_rec = 0;
      end
      chk("ctrl_ready", 32'(ctrl_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("ras_push", 32'(ras_push), 32'(e_push));
      chk("ras_pop", 32'(ras_pop), 32'(e_pop));
      chk("ras_new_addr", ras_new_addr, e_addr);
      chk("predict_valid", 32'(predict_valid), 32'(e_pv));
      chk("predict_addr", predict_addr, ras_addr);
      s_push = ras_push; s_pop = ras_pop; s_addr = ras_new_addr;
      if (busy) busy_cnt++;
      if (ras_push || ras_pop) ras_ops++;
      @(posedge clk);
      #1;
      apply_ras(s_push, s_pop, s_addr);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(0, 0, 0, 32'h0, 0, 0);
   endtask

   task automatic call_op(input logic [31:0] a);
      cycle(1, 1, 0, a, 0, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   logic [31:0] pre_top;

   initial begin
      refresh_ras();
      // reset state
      repeat (2) @(posedge clk);
      fetch_valid = 1; fetch_is_call = 1; fetch_ret_addr = 32'hdead;
      #1;
      chk("rst_push", 32'(ras_push), 32'h0);
      chk("rst_pop", 32'(ras_pop), 32'h0);
      chk("rst_new_addr", ras_new_addr, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      fetch_valid = 0; fetch_is_call = 0;
      @(negedge clk);
      rst_n = 1;
      idle(1);

      // seed the RAS with one entry so rollback has something to preserve
      call_op(32'h50);
      cycle(0, 0, 0, 0, 1, 0);

      // two calls, a return, flush: three undo cycles, RAS unchanged
      pre_top = ras_addr;
      busy_cnt = 0;
      call_op(32'h100);
      call_op(32'h200);
      cycle(1, 0, 1, 32'h0, 0, 0);
      cycle(0, 0, 0, 32'h0, 0, 1);
      idle(4);
      chk("t41_busy_cycles", busy_cnt, 32'd3);
      chk("t41_top_restored", ras_addr, pre_top);

      // committed call survives, only the later call is undone
      busy_cnt = 0;
      call_op(32'h100);
      cycle(0, 0, 0, 32'h0, 1, 0);
      call_op(32'h200);
      cycle(0, 0, 0, 32'h0, 0, 1);
      idle(3);
      chk("t42_busy_cycles", busy_cnt, 32'd1);
      chk("t42_predict_addr", predict_addr, 32'h100);

      // log full blocks fetch until a commit frees a slot
      repeat (4) call_op(32'h1000 + $urandom_range(0, 255));
      #1;
      chk("t43_full_not_ready", 32'(ctrl_ready), 32'h0);
      ras_ops = 0;
      cycle(1, 1, 0, 32'h2000, 0, 0);
      cycle(1, 1, 0, 32'h2000, 1, 0);
      chk("t43_blocked_no_ops", ras_ops, 32'd0);
      cycle(1, 1, 0, 32'h2004, 0, 0);
      chk("t43_accepted_after_commit", ras_ops, 32'd1);
      busy_cnt = 0;
      cycle(0, 0, 0, 32'h0, 0, 1);
      idle(5);
      chk("t43_busy_cycles", busy_cnt, 32'd4);

      // flush and commit together on a single entry
      call_op(32'h500);
      busy_cnt = 0; ras_ops = 0;
      cycle(0, 0, 0, 32'h0, 1, 1);
      idle(2);
      chk("t44_busy_never", busy_cnt, 32'd0);
      chk("t44_no_ras_ops", ras_ops, 32'd0);

      // swap then flush restores the old top in one cycle
      call_op(32'h300);
      cycle(0, 0, 0, 32'h0, 1, 0);
      cycle(1, 1, 1, 32'h400, 0, 0);
      chk("t45_swapped_top", ras_addr, 32'h400);
      busy_cnt = 0;
      cycle(0, 0, 0, 32'h0, 0, 1);
      idle(2);
      chk("t45_busy_cycles", busy_cnt, 32'd1);
      chk("t45_predict_addr", predict_addr, 32'h300);

      // reset in the middle of a rollback
      call_op(32'h600);
      call_op(32'h700);
      call_op(32'h800);
      cycle(0, 0, 0, 32'h0, 0, 1);
      cycle(0, 0, 0, 32'h0, 0, 0);
      @(negedge clk);
      #2;
      chk("t46_busy_before_rst", 32'(busy), 32'h1);
      rst_n = 0;
      #1;
      chk("t46_rst_busy", 32'(busy), 32'h0);
      chk("t46_rst_push", 32'(ras_push), 32'h0);
      chk("t46_rst_pop", 32'(ras_pop), 32'h0);
      chk("t46_rst_new_addr", ras_new_addr, 32'h0);
      mlog.delete();
      m_rec = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      chk("t46_ready_after_release", 32'(ctrl_ready), 32'h1);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         bit v, c, r, cm, fl;
         v  = ($urandom_range(0, 3) != 0);
         c  = $urandom_range(0, 1);
         r  = $urandom_range(0, 1);
         cm = ($urandom_range(0, 2) == 0);
         fl = ($urandom_range(0, 11) == 0);
         cycle(v, c, r, $urandom, cm, fl);
      end
      idle(DEPTH + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
